// File: rtl/sdrio_pkg.sv
// Shared definitions for the x1 SDR IO serializer/deserializer pair.
// Training defaults are also used by the serializer's pattern generator.
package sdrio_pkg;

  localparam int unsigned SDRIO_RATIO = 4;
  localparam logic [3:0] SDRIO_TRAIN_PATTERN = 4'b1100;
  localparam int unsigned SDRIO_LOCK_CNT = 8;
  localparam int unsigned SDRIO_MAX_SLIPS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSlip,
    StWait,
    StLocked,
    StFail
  } sdrio_rx_state_t;

endpackage

// File: rtl/sdrio_deser_core.sv
// Serial-to-parallel datapath: shift register, phase counter with slip hold,
// post-slip blanking and word capture.
module sdrio_deser_core #(
  parameter int unsigned Ratio = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rxd_i,
  input  logic             slip_i,
  output logic [Ratio-1:0] q_o,
  output logic             q_valid_o,
  output logic             slip_ack_o,
  output logic             blank_busy_o
);

  localparam int unsigned PhW = $clog2(Ratio);
  localparam logic [PhW-1:0] PhLast = PhW'(Ratio - 1);

  logic [Ratio-1:0] sr_q, sr_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [Ratio-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic [1:0]       blank_q, blank_d;
  logic             slip_go, capture;

  always_comb begin
    slip_go = slip_i && (blank_q == 2'd0);
    // A slip holds the phase, so it can never coincide with a capture.
    capture = (ph_q == PhLast) && !slip_go;
    sr_d    = {rxd_i, sr_q[Ratio-1:1]};
    ph_d    = slip_go ? ph_q : ph_q + PhW'(1);
    q_d     = capture ? sr_d : q_q;
    valid_d = capture;
    blank_d = blank_q;
    if (slip_go) begin
      blank_d = 2'd2;
    end else if (capture && (blank_q != 2'd0)) begin
      blank_d = blank_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q    <= '0;
      ph_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      blank_q <= 2'd0;
    end else begin
      sr_q    <= sr_d;
      ph_q    <= ph_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
    end
  end

  assign q_o          = q_q;
  assign q_valid_o    = valid_q;
  assign slip_ack_o   = slip_go;
  assign blank_busy_o = (blank_q != 2'd0);

endmodule

// File: rtl/sdrio_deser_x1.sv
// x1 SDR receive deserializer: datapath core plus word-alignment training FSM
// and manual bitslip arbitration.
module sdrio_deser_x1
  import sdrio_pkg::*;
#(
  parameter int unsigned       RATIO         = SDRIO_RATIO,
  parameter logic [RATIO-1:0]  TRAIN_PATTERN = SDRIO_TRAIN_PATTERN,
  parameter int unsigned       LOCK_CNT      = SDRIO_LOCK_CNT,
  parameter int unsigned       MAX_SLIPS     = SDRIO_MAX_SLIPS
) (
  input  logic             geclk_il,
  input  logic             rst_n,
  input  logic             rxd_in,
  input  logic             align_il,
  input  logic             train_en,
  output logic [RATIO-1:0] q_0,
  output logic             q_valid,
  output logic             locked,
  output logic             align_err,
  output logic [1:0]       slip_cnt
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned TryW   = $clog2(MAX_SLIPS + 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(LOCK_CNT);
  localparam logic [TryW-1:0]   TryMax   = TryW'(MAX_SLIPS);

  sdrio_rx_state_t   state_q, state_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [TryW-1:0]   try_q, try_d;
  logic [1:0]        slip_cnt_q, slip_cnt_d;
  logic              fsm_slip, manual_slip, slip_ack, blank_busy;

  sdrio_deser_core #(
    .Ratio(RATIO)
  ) u_core (
    .clk_i       (geclk_il),
    .rst_ni      (rst_n),
    .rxd_i       (rxd_in),
    .slip_i      (fsm_slip || manual_slip),
    .q_o         (q_0),
    .q_valid_o   (q_valid),
    .slip_ack_o  (slip_ack),
    .blank_busy_o(blank_busy)
  );

  // train_en has priority: a manual request in the cycle training starts is dropped.
  assign manual_slip = (state_q == StIdle) && !train_en && align_il;

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    try_d      = try_q;
    fsm_slip   = 1'b0;
    slip_cnt_d = slip_ack ? slip_cnt_q + 2'd1 : slip_cnt_q;
    if (!train_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCheck;
          match_d = '0;
          try_d   = '0;
        end
        StCheck: begin
          if (q_valid) begin
            if (q_0 == TRAIN_PATTERN) begin
              if (match_q != MatchMax) match_d = match_q + MatchW'(1);
              if (match_d == MatchMax) state_d = StLocked;
            end else begin
              match_d = '0;
              state_d = (try_q == TryMax) ? StFail : StSlip;
            end
          end
        end
        StSlip: begin
          fsm_slip = 1'b1;
          if (try_q != TryMax) try_d = try_q + TryW'(1);
          state_d = StWait;
        end
        StWait: begin
          if (!blank_busy) state_d = StCheck;
        end
        StLocked, StFail: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge geclk_il or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      match_q    <= '0;
      try_q      <= '0;
      slip_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      try_q      <= try_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign align_err = (state_q == StFail);
  assign slip_cnt  = slip_cnt_q;

endmodule

// File: tb/tb_sdrio_deser_x1.sv
// Directed bench for sdrio_deser_x1: reset, alignment training, failure,
// manual bitslip and train_en arbitration.
module tb_sdrio_deser_x1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b0;
  logic       align = 1'b0;
  logic       train_en = 1'b0;
  logic [3:0] q_0;
  logic       q_valid, locked, align_err;
  logic [1:0] slip_cnt;

  int checks = 0;
  int errors = 0;

  // Stream generator state: bit at edge n (from 1) is pat[(n-1+off)%4].
  logic [3:0] pat = 4'b1100;
  int idx = 0;
  int off = 0;
  int mode = 0;

  sdrio_deser_x1 dut (
    .geclk_il (clk),
    .rst_n    (rst_n),
    .rxd_in   (rxd),
    .align_il (align),
    .train_en (train_en),
    .q_0      (q_0),
    .q_valid  (q_valid),
    .locked   (locked),
    .align_err(align_err),
    .slip_cnt (slip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    rxd = (mode == 0) ? pat[(idx + off) % 4] : 1'b0;
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic do_reset(input int o, input int m, input logic te);
    rst_n = 1'b0;
    align = 1'b0;
    off = o;
    mode = m;
    train_en = te;
    @(posedge clk);
    #2;
    idx = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(0, 0, 1'b0);
    checks++;
    if ({q_0, q_valid, locked, align_err, slip_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {q_0, q_valid, locked, align_err, slip_cnt});
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (q_valid !== (i == 4)) begin
        errors++;
        $display("FAIL first_valid cycle %0d: got %b expected %b", i, q_valid, (i == 4));
      end
    end
    checks++;
    if (q_0 !== 4'b1100) begin
      errors++;
      $display("FAIL first_word: got %b expected 1100", q_0);
    end
  endtask

  task automatic test_aligned();
    int n = 0;
    do_reset(0, 0, 1'b1);
    for (int i = 0; i < 100 && n < 8; i++) begin
      if (q_valid) begin
        n++;
        checks++;
        if (q_0 !== 4'b1100) begin
          errors++;
          $display("FAIL aligned_word %0d: got %b expected 1100", n, q_0);
        end
        if (n == 8) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++;
            $display("FAIL aligned_early_lock: got %b expected 0", locked);
          end
        end
      end
      tick();
    end
    checks++;
    if (locked !== 1'b1 || slip_cnt !== 2'd0) begin
      errors++;
      $display("FAIL aligned_lock: got locked=%b slip_cnt=%0d expected 1,0", locked, slip_cnt);
    end
  endtask

  task automatic test_drop_locked();
    int n = 0;
    train_en = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL drop_unlock: got %b expected 0", locked);
    end
    train_en = 1'b1;
    tick();
    for (int i = 0; i < 100 && n < 8; i++) begin
      if (q_valid) begin
        n++;
        if (n == 8) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: got %b expected 0", locked);
          end
        end
      end
      tick();
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: got %b expected 1", locked);
    end
  endtask

  task automatic test_offset();
    int gap = 0;
    int maxgap = 0;
    bit seen = 0;
    do_reset(3, 0, 1'b1);
    for (int i = 0; i < 400 && !locked; i++) begin
      tick();
      gap++;
      if (q_valid) begin
        if (seen && gap > maxgap) maxgap = gap;
        seen = 1;
        gap = 0;
      end
    end
    checks++;
    if (locked !== 1'b1 || slip_cnt !== 2'd1) begin
      errors++;
      $display("FAIL offset_lock: got locked=%b slip_cnt=%0d expected 1,1", locked, slip_cnt);
    end
    checks++;
    if (maxgap != 5) begin
      errors++;
      $display("FAIL offset_strobe_gap: got %0d expected 5", maxgap);
    end
    for (int i = 0; i < 8 && !q_valid; i++) tick();
    checks++;
    if (q_valid !== 1'b1 || q_0 !== 4'b1100) begin
      errors++;
      $display("FAIL offset_word: got valid=%b q=%b expected 1,1100", q_valid, q_0);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q_0, q_valid, locked, align_err, slip_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {q_0, q_valid, locked, align_err, slip_cnt});
    end
  endtask

  task automatic test_fail();
    int slips = 0;
    logic [1:0] prev;
    do_reset(0, 1, 1'b1);
    prev = slip_cnt;
    for (int i = 0; i < 600 && !align_err; i++) begin
      tick();
      if (slip_cnt !== prev) slips++;
      prev = slip_cnt;
    end
    checks++;
    if (align_err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL train_fail: got err=%b locked=%b expected 1,0", align_err, locked);
    end
    checks++;
    if (slips != 8 || slip_cnt !== 2'd0) begin
      errors++;
      $display("FAIL fail_slips: got %0d slips cnt=%0d expected 8,0", slips, slip_cnt);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (align_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", align_err);
    end
    train_en = 1'b0;
    tick();
    checks++;
    if ({locked, align_err} !== 2'b00) begin
      errors++;
      $display("FAIL fail_drop: got %b expected 00", {locked, align_err});
    end
  endtask

  task automatic test_manual();
    int gap = 0;
    do_reset(0, 0, 1'b0);
    for (int i = 0; i < 8 && !q_valid; i++) tick();
    align = 1'b1;
    tick();
    checks++;
    if (slip_cnt !== 2'd1) begin
      errors++;
      $display("FAIL manual_slip: got %0d expected 1", slip_cnt);
    end
    gap = 1;
    tick();
    gap++;
    align = 1'b0;
    for (int i = 0; i < 10 && !q_valid; i++) begin
      tick();
      gap++;
    end
    checks++;
    if (gap != 5 || q_0 !== 4'b0110) begin
      errors++;
      $display("FAIL manual_gap: got gap=%0d q=%b expected 5,0110", gap, q_0);
    end
    checks++;
    if (slip_cnt !== 2'd1) begin
      errors++;
      $display("FAIL blank_ignore: got %0d expected 1", slip_cnt);
    end
    gap = 0;
    tick();
    gap++;
    for (int i = 0; i < 10 && !q_valid; i++) begin
      tick();
      gap++;
    end
    checks++;
    if (gap != 4 || q_0 !== 4'b0110) begin
      errors++;
      $display("FAIL manual_next: got gap=%0d q=%b expected 4,0110", gap, q_0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(0, 0, 1'b0);
    tick();
    tick();
    align = 1'b1;
    train_en = 1'b1;
    tick();
    align = 1'b0;
    checks++;
    if (slip_cnt !== 2'd0) begin
      errors++;
      $display("FAIL train_wins: got %0d expected 0", slip_cnt);
    end
    for (int i = 0; i < 100 && !locked; i++) tick();
    checks++;
    if (locked !== 1'b1 || slip_cnt !== 2'd0) begin
      errors++;
      $display("FAIL train_wins_lock: got locked=%b cnt=%0d expected 1,0", locked, slip_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_drop_locked();
    test_offset();
    test_reset_mid();
    test_fail();
    test_manual();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrio_deser_x1.md
Name: sdrio_deser_x1

Overview:
- Receive-side counterpart of the x1 SDR output serializer.
- Takes one serial bit per cycle from the GPIO input cell (rxd_in, sampled on geclk_il) and assembles 4-bit words with a one-cycle valid strobe.
- Word boundary is adjusted by bitslip, either manually or through a training FSM that locks onto a known pattern.
- Sits between the IO cell rxd path and the PHY read datapath; bit order matches the serializer: first bit on the wire lands in q_0[0].

Parameters:
- RATIO, 4, serial-to-parallel ratio. Fixed at 4; other values are unsupported.
- TRAIN_PATTERN, 4'b1100, expected word during training. Its four rotations must be distinct.
- LOCK_CNT, 8, consecutive matching words required to declare lock.
- MAX_SLIPS, 8, slips attempted before training fails.

Ports:
- geclk_il  in  1  fast edge clock, sole clock.
- rst_n  in  1  asynchronous active-low reset.
- rxd_in  in  1  serial sample from the IO cell, one bit per cycle.
- align_il  in  1  manual bitslip request; single-cycle pulse.
- train_en  in  1  level; high runs the training FSM.
- q_0  out  4  assembled word; q_0[0] is the earliest bit.
- q_valid  out  1  one-cycle strobe, q_0 is valid.
- locked  out  1  training lock achieved.
- align_err  out  1  training failed (sticky until train_en low or reset).
- slip_cnt  out  2  total slips applied, mod 4.

Behaviour:
- Reset (rst_n low, async): sr, ph_cnt, q_0, q_valid, locked, align_err, slip_cnt, match_cnt, slip_try and blank all go to 0; FSM goes to IDLE. Reset mid-training aborts with no residue.
- Shift: every cycle, sr <= {rxd_in, sr[3:1]}.
- Phase counter: ph_cnt increments mod 4 each cycle, except in a slip cycle, where it holds.
- Capture: when ph_cnt==3 and not a slip cycle, q_0 <= {rxd_in, sr[3:1]} and q_valid <= 1. Otherwise q_valid <= 0.
- Latency: the last bit of a word appears on q_0 one cycle after it is on rxd_in.
- Slip effect: a slip moves the word boundary one bit later. The affected word interval is 5 cycles, with no lost strobe. slip_cnt increments mod 4.
- Blanking: after any slip, blank=2 and decrements on each capture. Slip requests are ignored while blank != 0. q_valid still pulses during blanking.
- Manual slip: align_il is honored only in IDLE and only when blank==0; it is ignored in all other states.
- Training FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
  - IDLE: locked=0. Go to CHECK when train_en=1; match_cnt and slip_try are cleared on entry.
  - CHECK: acts on each capture.
    - Word == TRAIN_PATTERN: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED.
    - Mismatch: match_cnt=0. Go to SLIP, or to FAIL if slip_try==MAX_SLIPS.
  - SLIP: issue one internal slip, slip_try++, go to WAIT. Always a single cycle.
  - WAIT: go to CHECK when blank reaches 0.
  - LOCKED: locked=1. Mismatches are ignored; data passes through.
  - FAIL: align_err=1.
  - From any state, train_en=0 returns to IDLE next cycle, with locked=0 and align_err=0 in that same cycle.
- Simultaneous events:
  - align_il in the same cycle as train_en rising: train_en wins and the manual slip is dropped.
  - A capture coinciding with a slip cycle cannot occur, because the slip holds ph_cnt.
- Wrap-around: slip_cnt wraps 3->0. match_cnt saturates at LOCK_CNT. slip_try saturates at MAX_SLIPS.

Decomposition:
- Shared package sdrio_pkg holds:
  - FSM state enum (sdrio_rx_state_t);
  - constant SDRIO_RATIO=4;
  - default training pattern;
  - LOCK_CNT and MAX_SLIPS defaults (also used by the serializer's training generator).
- Sub-module sdrio_deser_core holds the shift register, phase counter, slip hold, blanking and capture. Inputs are a slip pulse and rxd_in; outputs are q_0, q_valid and slip_ack.
- The top level holds the training FSM and the manual-slip arbitration.

Test Plan:
- Reset: drive rst_n low mid-stream -> all outputs 0 within the same cycle. Release rst_n -> first q_valid on the 4th cycle.
- Aligned stream: repeated 1100 (bits 0,0,1,1 LSB-first) with train_en=1 -> q_0=4'b1100 every 4 cycles, locked=1 after the 8th match, slip_cnt=0.
- Stream offset by 1 bit: -> FSM slips until q_0==4'b1100, then locked=1. slip_cnt equals the number of slips applied (≤3), and no strobe is lost.
- Random or constant-0 data with train_en=1: -> 8 slips, then align_err=1 and locked=0. Drop train_en -> both 0 next cycle.
- Manual align_il pulse in IDLE: -> one 5-cycle q_valid interval, slip_cnt 0->1. A second pulse within blanking is ignored (slip_cnt stays 1).
- train_en dropped while LOCKED: -> IDLE with locked=0 next cycle. Re-raise train_en -> re-lock after 8 matching words.
